// File: rtl/pipe_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage.
// Owns HI/LO and stalls the pipeline while a result is pending.
module pipe_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             rd_hilo_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q, neg_q, rneg_q, bz_q, dz_q, done_q;
    logic [WIDTH-1:0] a_raw_q, opb_q, acc_hi_q, acc_lo_q, hi_q, lo_q;

    logic             sgn;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   sum, shl, diff;
    logic [WIDTH-1:0] acc_hi_d, acc_lo_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign sgn   = ~op_i[0];
    assign a_abs = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;

    // Multiply: shift-add with multiplier in acc_lo. Divide: restoring,
    // remainder in acc_hi and dividend shifting out of acc_lo into quotient.
    always_comb begin
        sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        shl      = {acc_hi_q, acc_lo_q[WIDTH-1]};
        diff     = shl - {1'b0, opb_q};
        acc_hi_d = sum[WIDTH:1];
        acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        if (div_q) begin
            if (!diff[WIDTH]) begin
                acc_hi_d = diff[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_d = shl[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign prod_fix = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    assign q_fix    = neg_q ? -acc_lo_q : acc_lo_q;
    assign r_fix    = rneg_q ? -acc_hi_q : acc_hi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bz_q     <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            a_raw_q  <= '0;
            opb_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (wr_hi_i) hi_q <= wdata_i;
                    if (wr_lo_i) lo_q <= wdata_i;
                    if (start_i && !flush_i) begin
                        state_q  <= RUN;
                        cnt_q    <= '0;
                        div_q    <= op_i[1];
                        neg_q    <= sgn & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        rneg_q   <= sgn & a_i[WIDTH-1];
                        bz_q     <= (b_i == '0);
                        dz_q     <= 1'b0;
                        a_raw_q  <= a_i;
                        acc_hi_q <= '0;
                        opb_q    <= op_i[1] ? b_abs : a_abs;
                        acc_lo_q <= op_i[1] ? a_abs : b_abs;
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        acc_hi_q <= acc_hi_d;
                        acc_lo_q <= acc_lo_d;
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    if (!flush_i) begin
                        done_q <= 1'b1;
                        if (div_q && bz_q) begin
                            hi_q <= a_raw_q;
                            lo_q <= '1;
                            dz_q <= 1'b1;
                        end else if (div_q) begin
                            hi_q <= r_fix;
                            lo_q <= q_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign stall_o    = busy_o | (rd_hilo_i & busy_o)
                      | (start_i & (state_q == IDLE) & ~flush_i);

endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// Directed bench for pipe_muldiv_unit (WIDTH=32).
// Each task drives one scenario and checks its own expectations.
module tb_pipe_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0, b_i = '0;
    logic        flush_i = 1'b0, rd_hilo_i = 1'b0;
    logic        wr_hi_i = 1'b0, wr_lo_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        busy_o, done_o, div_zero_o, stall_o;
    logic [31:0] hi_o, lo_o;

    int total = 0;
    int bad = 0;

    pipe_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .rd_hilo_i(rd_hilo_i),
        .wr_hi_i(wr_hi_i), .wr_lo_i(wr_lo_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .div_zero_o(div_zero_o),
        .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, run until done_o (bounded), report latency and stall count.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int stalls);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        tick();
        start_i = 1'b0;
        lat = 0; stalls = 0;
        while (!done_o && lat < 100) begin
            if (stall_o) stalls++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0 || busy_o !== 1'b0 || done_o !== 1'b0
            || div_zero_o !== 1'b0 || stall_o !== 1'b0) begin
            bad++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b stall=%b want all 0",
                     hi_o, lo_o, busy_o, done_o, div_zero_o, stall_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_multu();
        int lat, st;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, st);
        total++;
        if (lat !== 33) begin
            bad++; $display("FAIL multu_latency: got %0d want 33", lat);
        end
        total++;
        if (hi_o !== 32'hFFFFFFFE || lo_o !== 32'h00000001) begin
            bad++; $display("FAIL multu_result: hi=%h lo=%h want fffffffe 00000001", hi_o, lo_o);
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++; $display("FAIL busy_at_done: got %b want 0", busy_o);
        end
        tick();
        total++;
        if (done_o !== 1'b0) begin
            bad++; $display("FAIL done_pulse_width: got %b want 0", done_o);
        end
    endtask

    task automatic test_mult_stall();
        int lat, st;
        start_i = 1'b1; op_i = 2'b00; a_i = 32'hFFFFFFF9; b_i = 32'd6;
        #1;
        total++;
        if (stall_o !== 1'b1) begin
            bad++; $display("FAIL stall_accept: got %b want 1", stall_o);
        end
        run_op(2'b00, 32'hFFFFFFF9, 32'd6, lat, st);
        total++;
        if (st !== 33 || lat !== 33) begin
            bad++; $display("FAIL mult_stall: stalls=%0d lat=%0d want 33 33", st, lat);
        end
        total++;
        if (stall_o !== 1'b0) begin
            bad++; $display("FAIL stall_at_done: got %b want 0", stall_o);
        end
        total++;
        if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFD6) begin
            bad++; $display("FAIL mult_result: hi=%h lo=%h want ffffffff ffffffd6", hi_o, lo_o);
        end
    endtask

    task automatic test_div();
        int lat, st;
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, st);
        total++;
        if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFD || lat !== 33) begin
            bad++; $display("FAIL div_signed: hi=%h lo=%h lat=%0d want ffffffff fffffffd 33",
                            hi_o, lo_o, lat);
        end
        run_op(2'b11, 32'd100, 32'd7, lat, st);
        total++;
        if (hi_o !== 32'd2 || lo_o !== 32'd14) begin
            bad++; $display("FAIL divu: hi=%0d lo=%0d want 2 14", hi_o, lo_o);
        end
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, st);
        total++;
        if (hi_o !== 32'h0 || lo_o !== 32'h80000000 || div_zero_o !== 1'b0) begin
            bad++; $display("FAIL div_overflow: hi=%h lo=%h dz=%b want 0 80000000 0",
                            hi_o, lo_o, div_zero_o);
        end
    endtask

    task automatic test_div_zero();
        int lat, st;
        run_op(2'b11, 32'h1234, 32'h0, lat, st);
        total++;
        if (hi_o !== 32'h1234 || lo_o !== 32'hFFFFFFFF || div_zero_o !== 1'b1 || lat !== 33) begin
            bad++; $display("FAIL div_zero: hi=%h lo=%h dz=%b lat=%0d want 1234 ffffffff 1 33",
                            hi_o, lo_o, div_zero_o, lat);
        end
        start_i = 1'b1; op_i = 2'b11; a_i = 32'd100; b_i = 32'd7;
        tick();
        start_i = 1'b0;
        total++;
        if (div_zero_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++; $display("FAIL dz_clear: dz=%b busy=%b want 0 1", div_zero_o, busy_o);
        end
        for (int i = 0; i < 40 && !done_o; i++) tick();
        total++;
        if (hi_o !== 32'd2 || lo_o !== 32'd14) begin
            bad++; $display("FAIL divu_after_dz: hi=%0d lo=%0d want 2 14", hi_o, lo_o);
        end
    endtask

    task automatic test_flush();
        int lat, st;
        logic [31:0] ph, pl;
        logic seen;
        ph = hi_o; pl = lo_o; seen = 1'b0;
        start_i = 1'b1; op_i = 2'b00; a_i = 32'd3; b_i = 32'd5;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done_o) seen = 1'b1;
            tick();
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || seen) begin
            bad++; $display("FAIL flush_abort: busy=%b done=%b early=%b want 0 0 0",
                            busy_o, done_o, seen);
        end
        total++;
        if (hi_o !== ph || lo_o !== pl) begin
            bad++; $display("FAIL flush_hold: hi=%h lo=%h want %h %h", hi_o, lo_o, ph, pl);
        end
        flush_i = 1'b1; start_i = 1'b1;
        tick();
        flush_i = 1'b0; start_i = 1'b0;
        total++;
        if (busy_o !== 1'b0) begin
            bad++; $display("FAIL flush_blocks_start: busy=%b want 0", busy_o);
        end
        run_op(2'b01, 32'd3, 32'd5, lat, st);
        total++;
        if (hi_o !== 32'd0 || lo_o !== 32'd15 || lat !== 33) begin
            bad++; $display("FAIL restart: hi=%0d lo=%0d lat=%0d want 0 15 33", hi_o, lo_o, lat);
        end
    endtask

    task automatic test_mthilo();
        wr_lo_i = 1'b1; wdata_i = 32'hA5A5A5A5;
        #1;
        total++;
        if (lo_o !== 32'd15) begin
            bad++; $display("FAIL mtlo_early: lo=%h want 0000000f", lo_o);
        end
        tick();
        wr_lo_i = 1'b0;
        total++;
        if (lo_o !== 32'hA5A5A5A5 || hi_o !== 32'd0) begin
            bad++; $display("FAIL mtlo: hi=%h lo=%h want 0 a5a5a5a5", hi_o, lo_o);
        end
        wr_hi_i = 1'b1; wr_lo_i = 1'b1; wdata_i = 32'h0F0F0F0F;
        tick();
        wr_hi_i = 1'b0; wr_lo_i = 1'b0;
        total++;
        if (hi_o !== 32'h0F0F0F0F || lo_o !== 32'h0F0F0F0F) begin
            bad++; $display("FAIL mthi_mtlo: hi=%h lo=%h want 0f0f0f0f x2", hi_o, lo_o);
        end
        start_i = 1'b1; op_i = 2'b01; a_i = 32'd9; b_i = 32'd9;
        tick();
        start_i = 1'b0;
        tick(); tick();
        wr_hi_i = 1'b1; wr_lo_i = 1'b1; wdata_i = 32'h12345678; rd_hilo_i = 1'b1;
        #1;
        total++;
        if (stall_o !== 1'b1) begin
            bad++; $display("FAIL stall_rd_hilo: got %b want 1", stall_o);
        end
        tick();
        wr_hi_i = 1'b0; wr_lo_i = 1'b0; rd_hilo_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        total++;
        if (hi_o !== 32'h0F0F0F0F || lo_o !== 32'h0F0F0F0F) begin
            bad++; $display("FAIL mt_busy_drop: hi=%h lo=%h want 0f0f0f0f x2", hi_o, lo_o);
        end
    endtask

    task automatic test_async_reset();
        start_i = 1'b1; op_i = 2'b00; a_i = 32'd7; b_i = 32'd7;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #1 rst = 1'b1;
        #1;
        total++;
        if (busy_o !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0 || stall_o !== 1'b0) begin
            bad++; $display("FAIL async_reset: busy=%b hi=%h lo=%h stall=%b want 0",
                            busy_o, hi_o, lo_o, stall_o);
        end
        #1 rst = 1'b0;
        tick();
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            bad++; $display("FAIL post_reset: busy=%b done=%b want 0 0", busy_o, done_o);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_stall();
        test_div();
        test_div_zero();
        test_flush();
        test_mthilo();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
